// File: rtl/step_run_controller.sv
// Run/halt/single-step sequencer: conditions three raw buttons and produces the
// datapath clock-enable plus an executed-instruction counter. reset_i is active-low.
module step_run_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter logic [31:0] HALT_INSTR      = 32'hFFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        run_btn_i,
    input  logic        step_btn_i,
    input  logic        halt_btn_i,
    input  logic        bp_enable_i,
    input  logic [31:0] bp_addr_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic        cpu_en_o,
    output logic [1:0]  state_o,
    output logic        bp_hit_o,
    output logic        halt_seen_o,
    output logic [31:0] instr_count_o
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        STEP = 2'b10,
        HALT = 2'b11
    } state_e;

    logic [2:0]            btnRaw;
    logic [2:0]            syncA_q;
    logic [2:0]            syncB_q;
    logic [2:0]            level_q;
    logic [2:0]            levelPrev_q;
    logic [2:0][CNT_W-1:0] dbCnt_q;
    logic [2:0]            btnPulse;
    logic                  runPulse;
    logic                  stepPulse;
    logic                  haltPulse;

    state_e                state_q;
    state_e                state_d;
    logic                  bpHit_q;
    logic                  bpHit_d;
    logic                  haltSeen_q;
    logic                  haltSeen_d;
    logic                  skipBp_q;
    logic                  skipBp_d;
    logic [31:0]           instrCount_q;
    logic                  cpuEn;
    logic                  bpTerm;
    logic                  haltTerm;
    logic                  stopCond;

    assign btnRaw = {halt_btn_i, step_btn_i, run_btn_i};

    // A level is only accepted after the synchronized input has disagreed with it
    // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            syncA_q     <= '0;
            syncB_q     <= '0;
            level_q     <= '0;
            levelPrev_q <= '0;
            dbCnt_q     <= '0;
        end else begin
            syncA_q     <= btnRaw;
            syncB_q     <= syncA_q;
            levelPrev_q <= level_q;
            for (int b = 0; b < 3; b++) begin
                if (dbCnt_q[b] == CNT_W'(DEBOUNCE_CYCLES)) begin
                    level_q[b] <= syncB_q[b];
                    dbCnt_q[b] <= '0;
                end else if (syncB_q[b] != level_q[b]) begin
                    dbCnt_q[b] <= dbCnt_q[b] + CNT_W'(1);
                end else begin
                    dbCnt_q[b] <= '0;
                end
            end
        end
    end

    assign btnPulse  = level_q & ~levelPrev_q;
    assign runPulse  = btnPulse[0];
    assign stepPulse = btnPulse[1];
    assign haltPulse = btnPulse[2];

    assign bpTerm   = bp_enable_i & (pc_i == bp_addr_i) & ~skipBp_q;
    assign haltTerm = (instr_i == HALT_INSTR);
    assign stopCond = bpTerm | haltTerm;

    // The enable is decoded combinationally so a matching breakpoint or halt
    // instruction is blocked in the very cycle it is presented.
    always_comb begin
        state_d    = state_q;
        bpHit_d    = bpHit_q;
        haltSeen_d = haltSeen_q;
        skipBp_d   = skipBp_q;
        cpuEn      = 1'b0;
        case (state_q)
            IDLE: begin
                if (haltPulse) begin
                    state_d = HALT;
                end else if (stepPulse) begin
                    state_d = STEP;
                end else if (runPulse) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                skipBp_d = 1'b0;
                if (stopCond) begin
                    state_d    = HALT;
                    bpHit_d    = bpHit_q | bpTerm;
                    haltSeen_d = haltSeen_q | haltTerm;
                end else begin
                    cpuEn = 1'b1;
                    if (haltPulse) begin
                        state_d = HALT;
                    end
                end
            end
            STEP: begin
                cpuEn   = ~haltTerm;
                state_d = HALT;
                if (haltTerm) begin
                    haltSeen_d = 1'b1;
                end
            end
            HALT: begin
                // Resuming arms the skip so the breakpointed instruction itself executes.
                if (!haltPulse && (stepPulse || runPulse)) begin
                    bpHit_d    = 1'b0;
                    haltSeen_d = 1'b0;
                    if (stepPulse) begin
                        state_d = STEP;
                    end else begin
                        state_d  = RUN;
                        skipBp_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q      <= IDLE;
            bpHit_q      <= 1'b0;
            haltSeen_q   <= 1'b0;
            skipBp_q     <= 1'b0;
            instrCount_q <= '0;
        end else begin
            state_q      <= state_d;
            bpHit_q      <= bpHit_d;
            haltSeen_q   <= haltSeen_d;
            skipBp_q     <= skipBp_d;
            instrCount_q <= instrCount_q + 32'(cpuEn);
        end
    end

    assign cpu_en_o      = cpuEn;
    assign state_o       = state_q;
    assign bp_hit_o      = bpHit_q;
    assign halt_seen_o   = haltSeen_q;
    assign instr_count_o = instrCount_q;

endmodule

// File: tb/tb_step_run_controller.sv
// Bench for step_run_controller: directed scenarios plus a randomized run checked
// against a behavioural model (button history window + command rules).
module tb_step_run_controller;

    localparam int          D         = 4;
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
    localparam logic [31:0] NO_HALT   = 32'hFFFF_FF00;
    localparam logic [1:0]  S_IDLE    = 2'b00;
    localparam logic [1:0]  S_RUN     = 2'b01;
    localparam logic [1:0]  S_STEP    = 2'b10;
    localparam logic [1:0]  S_HALT    = 2'b11;

    logic        clk     = 1'b0;
    logic        rst_n   = 1'b1;
    logic        runBtn  = 1'b0;
    logic        stepBtn = 1'b0;
    logic        haltBtn = 1'b0;
    logic        bpEn    = 1'b0;
    logic [31:0] bpAddr  = '0;
    logic [31:0] pcIn    = '0;
    logic [31:0] instrIn = 32'h0000_0013;
    logic [31:0] haltPc  = NO_HALT;

    logic        cpuEn;
    logic [1:0]  stateOut;
    logic        bpHit;
    logic        haltSeen;
    logic [31:0] instrCount;

    int nCompared = 0;
    int nMismatch = 0;

    // Reference model state
    logic [1:0]  mState;
    logic        mBpHit, mHaltSeen, mSkip, mPrevEn;
    logic [31:0] mCount;
    logic [2:0]  mLevel, mLevelPrev;
    logic [D+2:0] mHist [3];
    logic        tEn, tBp, tHt, tAllDiff;
    logic [2:0]  tPulse, tRaw;
    logic [D+2:0] tH;

    always #5 clk = ~clk;

    step_run_controller #(.DEBOUNCE_CYCLES(D), .HALT_INSTR(HALT_WORD)) dut (
        .clk_i(clk), .reset_i(rst_n), .run_btn_i(runBtn), .step_btn_i(stepBtn),
        .halt_btn_i(haltBtn), .bp_enable_i(bpEn), .bp_addr_i(bpAddr), .pc_i(pcIn),
        .instr_i(instrIn), .cpu_en_o(cpuEn), .state_o(stateOut), .bp_hit_o(bpHit),
        .halt_seen_o(haltSeen), .instr_count_o(instrCount)
    );

    function automatic logic expEn();
        logic bpT, hT;
        bpT = bpEn && (pcIn == bpAddr) && !mSkip;
        hT  = (instrIn == HALT_WORD);
        case (mState)
            S_RUN:   expEn = !(bpT || hT);
            S_STEP:  expEn = !hT;
            default: expEn = 1'b0;
        endcase
    endfunction

    // A button level is accepted once the raw samples taken D+2..3 edges ago all
    // disagree with the current level; the new level is the sample from 2 edges ago.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mState <= S_IDLE; mBpHit <= 1'b0; mHaltSeen <= 1'b0; mSkip <= 1'b0;
            mPrevEn <= 1'b0; mCount <= '0; mLevel <= '0; mLevelPrev <= '0;
            for (int b = 0; b < 3; b++) mHist[b] <= '0;
        end else begin
            tBp    = bpEn && (pcIn == bpAddr) && !mSkip;
            tHt    = (instrIn == HALT_WORD);
            tPulse = mLevel & ~mLevelPrev;
            tEn    = expEn();
            mCount  <= mCount + (tEn ? 32'd1 : 32'd0);
            mPrevEn <= tEn;
            case (mState)
                S_IDLE: begin
                    if (tPulse[2]) mState <= S_HALT;
                    else if (tPulse[1]) mState <= S_STEP;
                    else if (tPulse[0]) mState <= S_RUN;
                end
                S_RUN: begin
                    mSkip <= 1'b0;
                    if (tBp || tHt) begin
                        mState <= S_HALT;
                        if (tBp) mBpHit <= 1'b1;
                        if (tHt) mHaltSeen <= 1'b1;
                    end else if (tPulse[2]) begin
                        mState <= S_HALT;
                    end
                end
                S_STEP: begin
                    mState <= S_HALT;
                    if (tHt) mHaltSeen <= 1'b1;
                end
                default: begin
                    if (!tPulse[2] && (tPulse[1] || tPulse[0])) begin
                        mBpHit <= 1'b0;
                        mHaltSeen <= 1'b0;
                        if (tPulse[1]) mState <= S_STEP;
                        else begin
                            mState <= S_RUN;
                            mSkip <= 1'b1;
                        end
                    end
                end
            endcase
            tRaw = {haltBtn, stepBtn, runBtn};
            for (int b = 0; b < 3; b++) begin
                tH = {mHist[b][D+1:0], tRaw[b]};
                mHist[b] <= tH;
                tAllDiff = 1'b1;
                for (int k = 3; k <= D + 2; k++) if (tH[k] == mLevel[b]) tAllDiff = 1'b0;
                if (tAllDiff) mLevel[b] <= tH[2];
            end
            mLevelPrev <= mLevel;
        end
    end

    // One cycle of the pretend datapath: the PC moves on only after an enabled cycle.
    task automatic tick();
        @(negedge clk);
        if (mPrevEn) pcIn = pcIn + 32'd4;
        instrIn = (pcIn == haltPc) ? HALT_WORD : {pcIn[15:0], 16'h0013};
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0; runBtn = 1'b0; stepBtn = 1'b0; haltBtn = 1'b0;
        pcIn = '0; instrIn = 32'h0000_0013;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic waitState(input logic [1:0] target, input int bound, output int used);
        used = 0;
        while (stateOut !== target && used < bound) begin
            tick();
            used++;
        end
    endtask

    task automatic test_reset();
        doReset();
        repeat (50) tick();
        nCompared++; if (stateOut !== S_IDLE) begin nMismatch++; $display("[TB] FAIL reset_state: got %b want %b", stateOut, S_IDLE); end
        nCompared++; if (cpuEn !== 1'b0) begin nMismatch++; $display("[TB] FAIL reset_cpu_en: got %b want 0", cpuEn); end
        nCompared++; if (instrCount !== 32'd0) begin nMismatch++; $display("[TB] FAIL reset_count: got %0d want 0", instrCount); end
        nCompared++; if (bpHit !== 1'b0 || haltSeen !== 1'b0) begin nMismatch++; $display("[TB] FAIL reset_flags: got %b%b want 00", bpHit, haltSeen); end
    endtask

    task automatic test_run_halt();
        int used;
        runBtn = 1'b1;
        waitState(S_RUN, D + 4, used);
        nCompared++; if (stateOut !== S_RUN) begin nMismatch++; $display("[TB] FAIL run_entry: got %b want %b", stateOut, S_RUN); end
        nCompared++; if (instrCount !== 32'd0) begin nMismatch++; $display("[TB] FAIL run_count0: got %0d want 0", instrCount); end
        for (int k = 1; k <= 8; k++) begin
            tick();
            nCompared++; if (instrCount !== 32'(k)) begin nMismatch++; $display("[TB] FAIL run_count_%0d: got %0d want %0d", k, instrCount, k); end
        end
        haltBtn = 1'b1;
        waitState(S_HALT, D + 6, used);
        nCompared++; if (stateOut !== S_HALT) begin nMismatch++; $display("[TB] FAIL halt_entry: got %b want %b", stateOut, S_HALT); end
        nCompared++; if (used !== D + 4) begin nMismatch++; $display("[TB] FAIL halt_latency: got %0d want %0d", used, D + 4); end
        nCompared++; if (cpuEn !== 1'b0) begin nMismatch++; $display("[TB] FAIL halt_cpu_en: got %b want 0", cpuEn); end
        repeat (5) tick();
        nCompared++; if (instrCount !== 32'(8 + D + 4)) begin nMismatch++; $display("[TB] FAIL halt_frozen: got %0d want %0d", instrCount, 8 + D + 4); end
        runBtn = 1'b0; haltBtn = 1'b0;
        repeat (D + 4) tick();
    endtask

    task automatic test_step();
        int enables;
        logic [31:0] startCount;
        startCount = mCount;
        enables = 0;
        for (int n = 0; n < 3; n++) begin
            stepBtn = 1'b1;
            repeat (D + 4) begin tick(); if (cpuEn === 1'b1) enables++; end
            stepBtn = 1'b0;
            repeat (D + 4) begin tick(); if (cpuEn === 1'b1) enables++; end
        end
        nCompared++; if (enables !== 3) begin nMismatch++; $display("[TB] FAIL step_enables: got %0d want 3", enables); end
        nCompared++; if (instrCount !== startCount + 32'd3) begin nMismatch++; $display("[TB] FAIL step_count: got %0d want %0d", instrCount, startCount + 32'd3); end
        nCompared++; if (stateOut !== S_HALT) begin nMismatch++; $display("[TB] FAIL step_state: got %b want %b", stateOut, S_HALT); end
        enables = 0;
        stepBtn = 1'b1;
        tick(); tick();
        stepBtn = 1'b0;
        repeat (2 * D + 6) begin tick(); if (cpuEn === 1'b1) enables++; end
        nCompared++; if (enables !== 0) begin nMismatch++; $display("[TB] FAIL step_glitch: got %0d enables want 0", enables); end
        nCompared++; if (stateOut !== S_HALT) begin nMismatch++; $display("[TB] FAIL step_glitch_state: got %b want %b", stateOut, S_HALT); end
    endtask

    task automatic test_breakpoint();
        int used;
        logic found;
        doReset();
        bpEn = 1'b1; bpAddr = 32'h10; runBtn = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (stateOut === S_RUN && pcIn === 32'h10) found = 1'b1;
        end
        nCompared++; if (found !== 1'b1) begin nMismatch++; $display("[TB] FAIL bp_reach: got %b want 1", found); end
        nCompared++; if (cpuEn !== 1'b0) begin nMismatch++; $display("[TB] FAIL bp_match_cycle: got %b want 0", cpuEn); end
        tick();
        nCompared++; if (stateOut !== S_HALT) begin nMismatch++; $display("[TB] FAIL bp_state: got %b want %b", stateOut, S_HALT); end
        nCompared++; if (bpHit !== 1'b1 || haltSeen !== 1'b0) begin nMismatch++; $display("[TB] FAIL bp_flags: got %b%b want 10", bpHit, haltSeen); end
        nCompared++; if (instrCount !== 32'd4) begin nMismatch++; $display("[TB] FAIL bp_count: got %0d want 4", instrCount); end
        runBtn = 1'b0;
        repeat (D + 4) tick();
        runBtn = 1'b1;
        waitState(S_RUN, D + 4, used);
        nCompared++; if (stateOut !== S_RUN) begin nMismatch++; $display("[TB] FAIL bp_resume_state: got %b want %b", stateOut, S_RUN); end
        nCompared++; if (cpuEn !== 1'b1) begin nMismatch++; $display("[TB] FAIL bp_resume_exec: got %b want 1", cpuEn); end
        nCompared++; if (bpHit !== 1'b0) begin nMismatch++; $display("[TB] FAIL bp_resume_clear: got %b want 0", bpHit); end
        tick(); tick();
        nCompared++; if (instrCount !== 32'd6 || stateOut !== S_RUN) begin nMismatch++; $display("[TB] FAIL bp_continue: got count %0d state %b want 6 %b", instrCount, stateOut, S_RUN); end
        runBtn = 1'b0; bpEn = 1'b0;
    endtask

    task automatic test_halt_instr();
        int enables;
        logic found;
        doReset();
        haltPc = 32'h20; runBtn = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            if (stateOut === S_RUN && pcIn === 32'h20) found = 1'b1;
        end
        nCompared++; if (found !== 1'b1 || cpuEn !== 1'b0) begin nMismatch++; $display("[TB] FAIL hi_same_cycle: got found %b en %b want 1 0", found, cpuEn); end
        tick();
        nCompared++; if (stateOut !== S_HALT || haltSeen !== 1'b1 || bpHit !== 1'b0) begin nMismatch++; $display("[TB] FAIL hi_stop: got state %b seen %b bp %b want 11 1 0", stateOut, haltSeen, bpHit); end
        nCompared++; if (instrCount !== 32'd8) begin nMismatch++; $display("[TB] FAIL hi_count: got %0d want 8", instrCount); end
        runBtn = 1'b0;
        repeat (D + 4) tick();
        enables = 0;
        stepBtn = 1'b1;
        repeat (D + 4) begin tick(); if (cpuEn === 1'b1) enables++; end
        stepBtn = 1'b0;
        repeat (D + 4) begin tick(); if (cpuEn === 1'b1) enables++; end
        nCompared++; if (enables !== 0 || haltSeen !== 1'b1 || stateOut !== S_HALT) begin nMismatch++; $display("[TB] FAIL hi_step: got en %0d seen %b state %b want 0 1 11", enables, haltSeen, stateOut); end
        haltPc = NO_HALT;
    endtask

    task automatic test_simultaneous();
        int used;
        doReset();
        runBtn = 1'b1; haltBtn = 1'b1;
        used = 0;
        while (stateOut === S_IDLE && used < D + 4) begin tick(); used++; end
        nCompared++; if (stateOut !== S_HALT) begin nMismatch++; $display("[TB] FAIL simul_state: got %b want %b", stateOut, S_HALT); end
        nCompared++; if (cpuEn !== 1'b0 || instrCount !== 32'd0) begin nMismatch++; $display("[TB] FAIL simul_idle: got en %b count %0d want 0 0", cpuEn, instrCount); end
        runBtn = 1'b0; haltBtn = 1'b0;
        repeat (D + 4) tick();
    endtask

    task automatic test_async_reset();
        int used;
        runBtn = 1'b1;
        waitState(S_RUN, D + 4, used);
        runBtn = 1'b0;
        repeat (3) tick();
        nCompared++; if (cpuEn !== 1'b1 || stateOut !== S_RUN) begin nMismatch++; $display("[TB] FAIL ar_pre: got en %b state %b want 1 01", cpuEn, stateOut); end
        @(posedge clk);
        #2;
        rst_n = 1'b0; pcIn = '0;
        #1;
        nCompared++; if (cpuEn !== 1'b0) begin nMismatch++; $display("[TB] FAIL ar_cpu_en: got %b want 0", cpuEn); end
        nCompared++; if (stateOut !== S_IDLE) begin nMismatch++; $display("[TB] FAIL ar_state: got %b want 00", stateOut); end
        nCompared++; if (instrCount !== 32'd0) begin nMismatch++; $display("[TB] FAIL ar_count: got %0d want 0", instrCount); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_random();
        int runLeft, stepLeft, haltLeft;
        runLeft = 0; stepLeft = 0; haltLeft = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (cyc % 500 == 0) begin
                haltPc = ($urandom_range(0, 2) == 0) ? 32'(4 * $urandom_range(4, 60)) : NO_HALT;
                doReset();
            end
            if (runLeft == 0) begin
                runBtn = ~runBtn;
                runLeft = runBtn ? $urandom_range(1, 3 * D) : $urandom_range(D, 6 * D);
            end else runLeft--;
            if (stepLeft == 0) begin
                stepBtn = ~stepBtn;
                stepLeft = stepBtn ? $urandom_range(1, 3 * D) : $urandom_range(2 * D, 8 * D);
            end else stepLeft--;
            if (haltLeft == 0) begin
                haltBtn = ~haltBtn;
                haltLeft = haltBtn ? $urandom_range(1, 2 * D) : $urandom_range(8 * D, 20 * D);
            end else haltLeft--;
            if ($urandom_range(0, 63) == 0) begin
                bpEn = $urandom_range(0, 1) == 1;
                bpAddr = 32'(4 * $urandom_range(0, 40));
            end
            tick();
            nCompared++; if (cpuEn !== expEn()) begin nMismatch++; $display("[TB] FAIL rnd_cpu_en @%0d: got %b want %b", cyc, cpuEn, expEn()); end
            nCompared++; if (stateOut !== mState) begin nMismatch++; $display("[TB] FAIL rnd_state @%0d: got %b want %b", cyc, stateOut, mState); end
            nCompared++; if (bpHit !== mBpHit) begin nMismatch++; $display("[TB] FAIL rnd_bp_hit @%0d: got %b want %b", cyc, bpHit, mBpHit); end
            nCompared++; if (haltSeen !== mHaltSeen) begin nMismatch++; $display("[TB] FAIL rnd_halt_seen @%0d: got %b want %b", cyc, haltSeen, mHaltSeen); end
            nCompared++; if (instrCount !== mCount) begin nMismatch++; $display("[TB] FAIL rnd_count @%0d: got %0d want %0d", cyc, instrCount, mCount); end
        end
        runBtn = 1'b0; stepBtn = 1'b0; haltBtn = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_run_halt();
        test_step();
        test_breakpoint();
        test_halt_instr();
        test_simultaneous();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/step_run_controller.md
# step_run_controller

Run/halt/single-step sequencer for the single-cycle datapath. It sits between the board buttons and the datapath and drives one clock-enable, `cpu_en`. That enable gates the PC update, register-file write and data-memory write, so the core can be started, stopped, single-stepped, or halted on a breakpoint or halt instruction. It also keeps a 32-bit executed-instruction counter for the seven-segment display mux.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable synchronized cycles required before a button level is accepted (use 4 for sim, ~1_000_000 on board).
- `HALT_INSTR`, default 32'hFFFF_FFFF: instruction word that stops execution.
- `clk` input, 1 bit: system clock; all state updates on the rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `run_btn` input, 1 bit: raw, asynchronous run button.
- `step_btn` input, 1 bit: raw, asynchronous single-step button.
- `halt_btn` input, 1 bit: raw, asynchronous halt button.
- `bp_enable` input, 1 bit: breakpoint armed.
- `bp_addr` input, 32 bits: breakpoint PC value.
- `pc` input, 32 bits: current PC from the datapath.
- `instr` input, 32 bits: instruction currently fetched at `pc`.
- `cpu_en` output, 1 bit: datapath enable; the PC and architectural writes advance only when this is 1.
- `state` output, 2 bits: IDLE=00, RUN=01, STEP=10, HALT=11.
- `bp_hit` output, 1 bit: last stop was caused by the breakpoint.
- `halt_seen` output, 1 bit: last stop was caused by `HALT_INSTR`.
- `instr_count` output, 32 bits: number of cycles with `cpu_en`=1.

## Operation
- **Button front end.** Each button has the same three-stage path:
  - a 2-flop synchronizer;
  - a debouncer: the counter increments while the synced value differs from the filtered level and clears otherwise; when it reaches DEBOUNCE_CYCLES, the filtered level takes the synced value and the counter clears;
  - a rising-edge detector that produces a one-cycle `*_pulse`.
- **Command priority** when pulses coincide: halt > step > run.
- **IDLE.** `cpu_en`=0.
  - `run_pulse` → RUN.
  - `step_pulse` → STEP.
  - `halt_pulse` → HALT.
- **RUN.**
  - `stop_cond` = (`bp_enable` & `pc`==`bp_addr` & !`skip_bp`) | (`instr`==HALT_INSTR).
  - `cpu_en` = !`stop_cond` (combinational, so the matching instruction does not execute).
  - If `stop_cond`, next state is HALT. `bp_hit` is set if the breakpoint term is true, and `halt_seen` is set if the halt term is true; both may be set.
  - Otherwise `halt_pulse` → HALT with `cpu_en` still 1 in the pulse cycle.
- **STEP.**
  - `cpu_en`=1 for exactly one cycle, unless `instr`==HALT_INSTR, in which case `cpu_en`=0 and `halt_seen`=1.
  - The breakpoint is ignored in STEP.
  - Next state is HALT unconditionally; pulses in the STEP cycle are dropped.
- **HALT.** `cpu_en`=0.
  - `run_pulse` → RUN; `step_pulse` → STEP.
  - Leaving HALT clears `bp_hit` and `halt_seen`.
- **Breakpoint skip.** `skip_bp` is set on any HALT→RUN transition and cleared after the first RUN cycle. This makes a resume from a breakpoint execute the breakpointed instruction instead of re-stopping.
- **HALT_INSTR resume.** Run and step pulses are accepted, but the core re-stops immediately because `pc` has not advanced. Recovery requires reset.
- **Counter.** `instr_count` increments by 1 on each edge where `cpu_en`=1 and wraps at 2^32. Only reset clears it.

## Timing
- **Reset values.** While `reset`=0, asynchronously:
  - `state`=IDLE, `cpu_en`=0, `bp_hit`=0, `halt_seen`=0, `instr_count`=0, `skip_bp`=0;
  - synchronizers, filters and debounce counters are 0.
- **Reset mid-RUN.** `cpu_en` drops in the same cycle that `reset` asserts, not at the next edge.
- **Button latency.** A button rising before edge k produces a pulse in cycle k+2+DEBOUNCE_CYCLES, and the state changes on the following edge.
- **Glitches.** A glitch shorter than DEBOUNCE_CYCLES cycles produces no pulse.
- **Held button.** Holding a button produces exactly one pulse; a release followed by a new press produces another.
- **Zero-latency outputs.** `cpu_en` is combinational from `state`, `pc`, `instr`, `bp_enable`, `bp_addr` and `skip_bp`. `state` is registered.

## Test plan
- **Reset defaults.** Release reset, no buttons, for 50 cycles → `state`=00, `cpu_en`=0, `instr_count`=0.
- **Run, then halt.**
  - Press run → RUN within DEBOUNCE_CYCLES+4 cycles.
  - `instr_count` increments by 1 per cycle.
  - Press halt → `state`=11, `cpu_en`=0, `instr_count` frozen.
- **Single step.** From HALT, press step 3 times with full releases between → exactly 3 cycles of `cpu_en`=1 and `instr_count`+3. A 2-cycle glitch on `step_btn` produces no step.
- **Breakpoint and resume.**
  - Set `bp_enable`=1, `bp_addr`=0x10, RUN with `pc` advancing by 4 → stop with `pc`=0x10, `cpu_en`=0 in the match cycle, `bp_hit`=1.
  - Press run → `pc`=0x10 executes, `bp_hit`=0, run continues.
- **Halt instruction.**
  - Drive `instr`=0xFFFF_FFFF during RUN → same-cycle `cpu_en`=0, then HALT with `halt_seen`=1.
  - Press step → `cpu_en` stays 0.
- **Simultaneous commands and async reset.**
  - Assert run and halt together from IDLE → HALT.
  - Assert `reset` low mid-RUN between edges → `cpu_en`=0 and `state`=00 immediately, `instr_count`=0.
